lsu: RTL and testbench

- Load/store unit for the pipelined RISC-V core's memory stage.
- Decodes a 32-bit byte address into a byte-addressed little-endian data memory, five memory-mapped output registers (LEDR, LEDG, HEX03, HEX47, LCD) and one read-only switch input.
- Stores are synchronous, with byte/half/word size masking.
- Loads are combinational, with size extraction and sign/zero extension.

---
 rtl/lsu.sv | 170 +++++++++++++++++
 tb/tb_lsu.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit for the memory stage: byte-addressed little-endian data memory,
// five memory-mapped output registers and a read-only switch port.
module lsu #(
    parameter int DMEM_ADDR_W = 11
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [3:0]  i_load_type,
    input  logic        i_load_signed,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_st_data,
    input  logic        i_lsu_wren,
    input  logic [31:0] i_io_sw,
    output logic [31:0] o_ld_data,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [31:0] o_io_lcd,
    output logic [31:0] o_io_hex03,
    output logic [31:0] o_io_hex47
);

    typedef enum logic [2:0] {
        REG_DMEM,
        REG_LEDR,
        REG_LEDG,
        REG_HEX03,
        REG_HEX47,
        REG_LCD,
        REG_SW,
        REG_NONE
    } region_e;

    localparam int DMEM_WORDS = 2 ** DMEM_ADDR_W;

    // Any size code other than byte or half is treated as a full word.
    function automatic logic [3:0] size_mask(input logic [3:0] load_type);
        case (load_type)
            4'h1:    return 4'h1;
            4'h3:    return 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] lane_bits(input logic [3:0] lanes);
        logic [31:0] bits;
        for (int i = 0; i < 4; i++) begin
            bits[8*i +: 8] = {8{lanes[i]}};
        end
        return bits;
    endfunction

    function automatic logic [31:0] format_load(
        input logic [31:0] word,
        input logic [3:0]  mask,
        input logic        sgn
    );
        case (mask)
            4'h1:    return {{24{sgn & word[7]}}, word[7:0]};
            4'h3:    return {{16{sgn & word[15]}}, word[15:0]};
            default: return word;
        endcase
    endfunction

    region_e                 region;
    logic [3:0]              mask;
    logic [1:0]              off;
    logic [4:0]              shamt;
    logic [DMEM_ADDR_W-1:0]  word_idx;
    logic [7:0]              dmem_lanes_wide;
    logic [3:0]              dmem_be;
    logic [31:0]             st_shifted;
    logic [31:0]             dmem_rd_word;
    logic [31:0]             dmem_ld_word;
    logic [31:0]             io_wr_bits;
    logic                    wr_en;

    logic [31:0] dmem [DMEM_WORDS];
    logic [31:0] ledr_q, ledg_q, hex03_q, hex47_q, lcd_q;

    always_comb begin
        region = REG_NONE;
        if (i_lsu_addr[31:16] == 16'h0000) begin
            region = REG_DMEM;
        end else begin
            case (i_lsu_addr[31:12])
                20'h10000: region = REG_LEDR;
                20'h10001: region = REG_LEDG;
                20'h10002: region = REG_HEX03;
                20'h10003: region = REG_HEX47;
                20'h10004: region = REG_LCD;
                20'h10010: region = REG_SW;
                default:   region = REG_NONE;
            endcase
        end
    end

    assign mask     = size_mask(i_load_type);
    assign off      = i_lsu_addr[1:0];
    assign shamt    = {off, 3'b000};
    assign word_idx = i_lsu_addr[DMEM_ADDR_W+1:2];

    // Lanes pushed past lane 3 by the offset fall off; accesses never span two words.
    assign dmem_lanes_wide = {4'b0000, mask} << off;
    assign dmem_be         = dmem_lanes_wide[3:0];
    assign st_shifted      = i_st_data << shamt;
    assign dmem_rd_word    = dmem[word_idx];
    assign dmem_ld_word    = dmem_rd_word >> shamt;

    assign io_wr_bits = lane_bits(mask);
    assign wr_en      = i_lsu_wren && !i_reset;

    // NOTE: the memory array has no reset branch; clearing 8 KiB in one cycle
    // would stop it mapping onto RAM, and software never relies on its contents.
    always_ff @(posedge i_clk) begin
        if (wr_en && region == REG_DMEM) begin
            for (int i = 0; i < 4; i++) begin
                if (dmem_be[i]) begin
                    dmem[word_idx][8*i +: 8] <= st_shifted[8*i +: 8];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ledr_q  <= '0;
            ledg_q  <= '0;
            hex03_q <= '0;
            hex47_q <= '0;
            lcd_q   <= '0;
        end else if (i_lsu_wren) begin
            case (region)
                REG_LEDR:  ledr_q  <= (ledr_q  & ~io_wr_bits) | (i_st_data & io_wr_bits);
                REG_LEDG:  ledg_q  <= (ledg_q  & ~io_wr_bits) | (i_st_data & io_wr_bits);
                REG_HEX03: hex03_q <= (hex03_q & ~io_wr_bits) | (i_st_data & io_wr_bits);
                REG_HEX47: hex47_q <= (hex47_q & ~io_wr_bits) | (i_st_data & io_wr_bits);
                REG_LCD:   lcd_q   <= (lcd_q   & ~io_wr_bits) | (i_st_data & io_wr_bits);
                default:   ;
            endcase
        end
    end

    // NOTE: o_ld_data gets a default before the case so no path infers a latch.
    always_comb begin
        o_ld_data = 32'h0;
        case (region)
            REG_DMEM:  o_ld_data = format_load(dmem_ld_word, mask, i_load_signed);
            REG_LEDR:  o_ld_data = format_load(ledr_q,  mask, i_load_signed);
            REG_LEDG:  o_ld_data = format_load(ledg_q,  mask, i_load_signed);
            REG_HEX03: o_ld_data = format_load(hex03_q, mask, i_load_signed);
            REG_HEX47: o_ld_data = format_load(hex47_q, mask, i_load_signed);
            REG_LCD:   o_ld_data = format_load(lcd_q,   mask, i_load_signed);
            REG_SW:    o_ld_data = format_load(i_io_sw, mask, i_load_signed);
            default:   o_ld_data = 32'h0;
        endcase
    end

    assign o_io_ledr  = format_load(ledr_q,  mask, i_load_signed);
    assign o_io_ledg  = format_load(ledg_q,  mask, i_load_signed);
    assign o_io_hex03 = format_load(hex03_q, mask, i_load_signed);
    assign o_io_hex47 = format_load(hex47_q, mask, i_load_signed);
    assign o_io_lcd   = format_load(lcd_q,   mask, i_load_signed);

    // Upper DMEM address bits alias and register offsets are ignored by design.
    logic unused_addr;
    assign unused_addr = &{1'b0, i_lsu_addr};

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu: IO register stores/formatting, switch reads,
// DMEM byte/half/word accesses, same-cycle load/store and reset behaviour.
module tb_lsu;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [3:0]  i_load_type;
    logic        i_load_signed;
    logic [31:0] i_lsu_addr;
    logic [31:0] i_st_data;
    logic        i_lsu_wren;
    logic [31:0] i_io_sw;
    logic [31:0] o_ld_data;
    logic [31:0] o_io_ledr;
    logic [31:0] o_io_ledg;
    logic [31:0] o_io_lcd;
    logic [31:0] o_io_hex03;
    logic [31:0] o_io_hex47;

    int passed = 0;
    int total  = 0;

    lsu #(.DMEM_ADDR_W(11)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_load_type   (i_load_type),
        .i_load_signed (i_load_signed),
        .i_lsu_addr    (i_lsu_addr),
        .i_st_data     (i_st_data),
        .i_lsu_wren    (i_lsu_wren),
        .i_io_sw       (i_io_sw),
        .o_ld_data     (o_ld_data),
        .o_io_ledr     (o_io_ledr),
        .o_io_ledg     (o_io_ledg),
        .o_io_lcd      (o_io_lcd),
        .o_io_hex03    (o_io_hex03),
        .o_io_hex47    (o_io_hex47)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] ltype);
        @(negedge i_clk);
        i_lsu_addr  = addr;
        i_st_data   = data;
        i_load_type = ltype;
        i_lsu_wren  = 1'b1;
        @(posedge i_clk);
        #1;
        i_lsu_wren  = 1'b0;
    endtask

    task automatic set_read(input logic [31:0] addr, input logic [3:0] ltype, input logic sgn);
        i_lsu_addr    = addr;
        i_load_type   = ltype;
        i_load_signed = sgn;
        #1;
    endtask

    initial begin
        i_reset       = 1'b1;
        i_load_type   = 4'hF;
        i_load_signed = 1'b0;
        i_lsu_addr    = 32'h0;
        i_st_data     = 32'h0;
        i_lsu_wren    = 1'b0;
        i_io_sw       = 32'h0;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_ledr",  o_io_ledr,  32'h0);
        check("rst_ledg",  o_io_ledg,  32'h0);
        check("rst_hex03", o_io_hex03, 32'h0);
        check("rst_hex47", o_io_hex47, 32'h0);
        check("rst_lcd",   o_io_lcd,   32'h0);
        @(negedge i_clk);
        i_reset = 1'b0;

        // IO registers: offset bits ignored, size mask applied to low bits
        do_store(32'h1000_40FF, 32'h3333_3333, 4'hF);
        set_read(32'h1000_40FF, 4'hF, 1'b0);
        check("lcd_word", o_io_lcd, 32'h3333_3333);
        check("lcd_ld",   o_ld_data, 32'h3333_3333);

        do_store(32'h1000_0053, 32'h1111_1111, 4'hF);
        set_read(32'h1000_0053, 4'h3, 1'b0);
        check("ledr_half_u", o_io_ledr, 32'h0000_1111);

        do_store(32'h1000_1103, 32'hBBBB_BBBB, 4'h3);
        set_read(32'h1000_1103, 4'h3, 1'b1);
        check("ledg_half_s", o_io_ledg, 32'hFFFF_BBBB);
        set_read(32'h1000_1103, 4'hF, 1'b1);
        check("ledg_word", o_io_ledg, 32'h0000_BBBB);

        do_store(32'h1000_2000, 32'hAAAA_AAAA, 4'hF);
        do_store(32'h1000_3000, 32'h5555_5555, 4'hF);
        do_store(32'h1000_2000, 32'h0000_0012, 4'h1);
        set_read(32'h1000_2004, 4'h1, 1'b1);
        check("hex03_byte_s", o_io_hex03, 32'h0000_0012);
        check("hex47_byte_s", o_io_hex47, 32'h0000_0055);
        set_read(32'h1000_2004, 4'hF, 1'b0);
        check("hex03_merge", o_io_hex03, 32'hAAAA_AA12);
        do_store(32'h1000_2000, 32'hAAAA_AAAA, 4'hF);
        set_read(32'h1000_2004, 4'h1, 1'b1);
        check("hex03_byte_neg", o_io_hex03, 32'hFFFF_FFAA);
        set_read(32'h1000_2004, 4'h1, 1'b0);
        check("hex03_ld_byte_u", o_ld_data, 32'h0000_00AA);
        set_read(32'h1000_2004, 4'h7, 1'b1);
        check("hex03_badsize", o_ld_data, 32'hAAAA_AAAA);

        // Switch input is read-only
        i_io_sw = 32'h8888_8888;
        set_read(32'h1001_00FF, 4'h3, 1'b1);
        check("sw_half_s", o_ld_data, 32'hFFFF_8888);
        do_store(32'h1001_00FF, 32'h1234_5678, 4'hF);
        set_read(32'h1001_00FF, 4'hF, 1'b0);
        check("sw_after_st", o_ld_data, 32'h8888_8888);
        check("sw_st_ledr",  o_io_ledr, 32'h1111_1111);
        check("sw_st_lcd",   o_io_lcd,  32'h3333_3333);

        // Unmapped address
        set_read(32'h2000_0000, 4'hF, 1'b0);
        check("unmapped_ld", o_ld_data, 32'h0);
        do_store(32'h2000_0000, 32'hDEAD_BEEF, 4'hF);
        check("unmapped_ledr", o_io_ledr, 32'h1111_1111);
        check("unmapped_ledg", o_io_ledg, 32'h0000_BBBB);

        // DMEM sub-word stores and loads
        do_store(32'h0000_0020, 32'h0000_0000, 4'hF);
        do_store(32'h0000_0022, 32'h1234_5678, 4'h3);
        set_read(32'h0000_0023, 4'h1, 1'b1);
        check("dmem_b23_s", o_ld_data, 32'h0000_0056);
        set_read(32'h0000_0022, 4'h1, 1'b1);
        check("dmem_b22_s", o_ld_data, 32'h0000_0078);
        set_read(32'h0000_0022, 4'h3, 1'b0);
        check("dmem_h22_u", o_ld_data, 32'h0000_5678);
        set_read(32'h0000_0020, 4'hF, 1'b0);
        check("dmem_w20", o_ld_data, 32'h5678_0000);
        do_store(32'h0000_0021, 32'h0000_0080, 4'h1);
        set_read(32'h0000_0021, 4'h1, 1'b1);
        check("dmem_b21_s", o_ld_data, 32'hFFFF_FF80);
        set_read(32'h0000_0021, 4'h1, 1'b0);
        check("dmem_b21_u", o_ld_data, 32'h0000_0080);
        set_read(32'h0000_2020, 4'hF, 1'b0);
        check("dmem_alias", o_ld_data, 32'h5678_8000);

        // Lanes beyond lane 3 are dropped
        do_store(32'h0000_0040, 32'h0000_0000, 4'hF);
        do_store(32'h0000_0044, 32'h0000_0000, 4'hF);
        do_store(32'h0000_0043, 32'hCAFE_BABE, 4'hF);
        set_read(32'h0000_0040, 4'hF, 1'b0);
        check("dmem_drop_w40", o_ld_data, 32'hBE00_0000);
        set_read(32'h0000_0044, 4'hF, 1'b0);
        check("dmem_drop_w44", o_ld_data, 32'h0000_0000);

        // Load in the store cycle sees pre-edge data
        @(negedge i_clk);
        i_lsu_addr  = 32'h0000_0020;
        i_st_data   = 32'h1122_3344;
        i_load_type = 4'hF;
        i_lsu_wren  = 1'b1;
        #1;
        check("same_cyc_old", o_ld_data, 32'h5678_8000);
        @(posedge i_clk);
        #1;
        i_lsu_wren = 1'b0;
        check("same_cyc_new", o_ld_data, 32'h1122_3344);

        // Reset beats a simultaneous store; DMEM retained
        @(negedge i_clk);
        i_reset     = 1'b1;
        i_lsu_addr  = 32'h1000_0000;
        i_st_data   = 32'hFFFF_FFFF;
        i_load_type = 4'hF;
        i_lsu_wren  = 1'b1;
        @(posedge i_clk);
        #1;
        i_lsu_wren = 1'b0;
        check("mid_rst_ledr",  o_io_ledr,  32'h0);
        check("mid_rst_ledg",  o_io_ledg,  32'h0);
        check("mid_rst_hex03", o_io_hex03, 32'h0);
        check("mid_rst_hex47", o_io_hex47, 32'h0);
        check("mid_rst_lcd",   o_io_lcd,   32'h0);
        @(negedge i_clk);
        i_reset = 1'b0;
        set_read(32'h0000_0020, 4'hF, 1'b0);
        check("dmem_kept", o_ld_data, 32'h1122_3344);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
